// File: rtl/output_gain_ramp.sv
// output_gain_ramp: stereo output gain stage with a ramped Q1.7 gain code.
// The gain code walks toward its target one accepted sample at a time, so
// gain changes and mute/unmute are click-free. The datapath is a two-stage
// pipeline: a full-width multiply, then a shift by 7 with saturation to 32 bits.
// Optional feature: define OUTPUT_GAIN_RAMP_CLIP_COUNT_EN to add the clip_count
// output, a saturating 16-bit count of clipped output samples.
module output_gain_ramp #(
  parameter int RAMP_STEP = 1
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [31:0] in_L,
  input  logic signed [31:0] in_R,
  input  logic               enable,
  input  logic [7:0]         gain_target,
  output logic signed [31:0] out_L,
  output logic signed [31:0] out_R,
  output logic               out_valid,
  output logic               ramp_busy,
`ifdef OUTPUT_GAIN_RAMP_CLIP_COUNT_EN
  output logic               clip,
  output logic [15:0]        clip_count
`else
  output logic               clip
`endif
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int FRAC_W = 7;

  localparam logic [COEF_W-1:0] STEP = COEF_W'(RAMP_STEP);

  // Saturation limits expressed at product width, and at output width
  localparam logic signed [PROD_W-1:0] SAT_HI = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_LO = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Ramp states carry bit 1 set so ramp_busy is a plain register bit
  typedef enum logic [1:0] {
    MUTED     = 2'b00,
    HOLD      = 2'b01,
    RAMP_UP   = 2'b10,
    RAMP_DOWN = 2'b11
  } state_t;

  function automatic state_t classify(input logic [COEF_W-1:0] g,
                                      input logic [COEF_W-1:0] e);
    if (g < e)       return RAMP_UP;
    else if (g > e)  return RAMP_DOWN;
    else if (g == 0) return MUTED;
    else             return HOLD;
  endfunction

  // Drop the Q1.7 fraction (arithmetic shift, truncates toward -inf) and clamp
  function automatic logic signed [DATA_W-1:0] sat_q7(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] s;
    s = p >>> FRAC_W;
    if (s > SAT_HI)      return OUT_MAX;
    else if (s < SAT_LO) return OUT_MIN;
    else                 return s[DATA_W-1:0];
  endfunction

  function automatic logic clips_q7(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] s;
    s = p >>> FRAC_W;
    return (s > SAT_HI) || (s < SAT_LO);
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COEF_W-1:0]   r_cur_gain;
  logic [COEF_W-1:0]   w_gain_nxt;
  logic [COEF_W-1:0]   w_eff;
  logic [COEF_W-1:0]   w_diff;
  logic [COEF_W-1:0]   w_delta;

  logic signed [PROD_W-1:0] w_in_l_x;
  logic signed [PROD_W-1:0] w_in_r_x;
  logic signed [PROD_W-1:0] w_gain_x;
  logic signed [PROD_W-1:0] r_prod_l_p1;
  logic signed [PROD_W-1:0] r_prod_r_p1;
  logic                     r_vld_p1;
  logic                     w_clip_p1;

  // Next gain and state: step toward the live target on each accepted sample
  always_comb begin
    w_eff       = enable ? gain_target : '0;
    w_diff      = '0;
    w_delta     = '0;
    w_gain_nxt  = r_cur_gain;
    w_state_nxt = r_state;
    if (sample_valid) begin
      if (r_cur_gain < w_eff) begin
        w_diff     = w_eff - r_cur_gain;
        w_delta    = (w_diff < STEP) ? w_diff : STEP;
        w_gain_nxt = r_cur_gain + w_delta;
      end else if (r_cur_gain > w_eff) begin
        w_diff     = r_cur_gain - w_eff;
        w_delta    = (w_diff < STEP) ? w_diff : STEP;
        w_gain_nxt = r_cur_gain - w_delta;
      end
      w_state_nxt = classify(w_gain_nxt, w_eff);
    end
  end

  // Gain code and ramp state registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= MUTED;
      r_cur_gain <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_gain <= w_gain_nxt;
    end
  end

  assign ramp_busy = r_state[1];

  // Operands widened to product width; gain is unsigned so it gets a zero sign bit
  assign w_in_l_x = {{(PROD_W-DATA_W){in_L[DATA_W-1]}}, in_L};
  assign w_in_r_x = {{(PROD_W-DATA_W){in_R[DATA_W-1]}}, in_R};
  assign w_gain_x = {{(PROD_W-COEF_W){1'b0}}, r_cur_gain};

  // ---- Stage p1: multiply by the gain in force before this sample's update ----
  always_ff @(posedge CLOCK_50) begin
    if (sample_valid) begin
      r_prod_l_p1 <= w_in_l_x * w_gain_x;
      r_prod_r_p1 <= w_in_r_x * w_gain_x;
    end
  end

  // Stage p1 valid: cleared by reset so in-flight samples are discarded
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= sample_valid;
  end

  assign w_clip_p1 = clips_q7(r_prod_l_p1) | clips_q7(r_prod_r_p1);

  // ---- Stage p2: shift, saturate and hold outputs between samples ----
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_L     <= '0;
      out_R     <= '0;
      clip      <= 1'b0;
    end else begin
      out_valid <= r_vld_p1;
      if (r_vld_p1) begin
        out_L <= sat_q7(r_prod_l_p1);
        out_R <= sat_q7(r_prod_r_p1);
        clip  <= w_clip_p1;
      end
    end
  end

`ifdef OUTPUT_GAIN_RAMP_CLIP_COUNT_EN
  logic [15:0] r_clip_count;

  // Count clipped samples (one per sample, not per channel), sticking at all-ones
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_clip_count <= '0;
    end else if (r_vld_p1 && w_clip_p1 && (r_clip_count != 16'hFFFF)) begin
      r_clip_count <= r_clip_count + 16'd1;
    end
  end

  assign clip_count = r_clip_count;
`endif

endmodule

// File: tb/tb_output_gain_ramp.sv
// Bench for output_gain_ramp: directed stimulus, a behavioural gain/ramp model
// with a per-cycle output comparison, and literal expectations at key points.
module tb_output_gain_ramp;

  localparam int STEP = 1;

  logic               CLOCK_50 = 1'b0;
  logic               reset = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [31:0] in_L = '0;
  logic signed [31:0] in_R = '0;
  logic               enable = 1'b0;
  logic [7:0]         gain_target = '0;
  logic signed [31:0] out_L;
  logic signed [31:0] out_R;
  logic               out_valid;
  logic               ramp_busy;
  logic               clip;
`ifdef OUTPUT_GAIN_RAMP_CLIP_COUNT_EN
  logic [15:0]        clip_count;
  int                 cc0;
`endif

  output_gain_ramp #(.RAMP_STEP(STEP)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .sample_valid (sample_valid),
    .in_L         (in_L),
    .in_R         (in_R),
    .enable       (enable),
    .gain_target  (gain_target),
    .out_L        (out_L),
    .out_R        (out_R),
    .out_valid    (out_valid),
    .ramp_busy    (ramp_busy),
`ifdef OUTPUT_GAIN_RAMP_CLIP_COUNT_EN
    .clip         (clip),
    .clip_count   (clip_count)
`else
    .clip         (clip)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int due;
    int l;
    int r;
    bit c;
  } exp_t;

  exp_t q[$];
  int   m_gain = 0;
  bit   m_busy = 1'b0;
  bit   m_busy_pend = 1'b0;
  int   m_pend_cyc = 0;
  int   hold_l = 0;
  int   hold_r = 0;
  bit   hold_c = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   rst_cyc = -100;
  bit   chk_on = 1'b0;
  int   dut_pulses = 0;
  int   p0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output value for sample x at gain code g (Q1.7): floor(x*g/128), clamped to int32
  function automatic int gain_apply(input int x, input int g, output bit c);
    longint v;
    v = (longint'(x) * longint'(g)) >>> 7;
    c = 1'b0;
    if (v > 64'sd2147483647) begin
      v = 64'sd2147483647;
      c = 1'b1;
    end else if (v < -64'sd2147483648) begin
      v = -64'sd2147483648;
      c = 1'b1;
    end
    return int'(v);
  endfunction

  task automatic send(input int l, input int r);
    int   eff;
    int   d;
    bit   cl;
    bit   cr;
    exp_t e;
    @(posedge CLOCK_50); #1;
    in_L = l;
    in_R = r;
    sample_valid = 1'b1;
    if (m_pend_cyc <= cyc) m_busy = m_busy_pend;
    eff = enable ? int'(gain_target) : 0;
    e.due = cyc + 2;
    e.l = gain_apply(l, m_gain, cl);
    e.r = gain_apply(r, m_gain, cr);
    e.c = cl | cr;
    q.push_back(e);
    if (m_gain < eff) begin
      d = eff - m_gain;
      m_gain += (d < STEP) ? d : STEP;
    end else if (m_gain > eff) begin
      d = m_gain - eff;
      m_gain -= (d < STEP) ? d : STEP;
    end
    m_busy_pend = (m_gain != eff);
    m_pend_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLOCK_50); #1;
      sample_valid = 1'b0;
    end
  endtask

  task automatic set_tgt(input bit en, input int g);
    @(posedge CLOCK_50); #1;
    sample_valid = 1'b0;
    enable = en;
    gain_target = 8'(g);
  endtask

  task automatic do_reset(input bit sv);
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
    sample_valid = sv;
    rst_cyc = cyc;
    q.delete();
    m_gain = 0;
    m_busy = 1'b0;
    m_busy_pend = 1'b0;
    m_pend_cyc = 0;
    hold_l = 0;
    hold_r = 0;
    hold_c = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic compare_loop();
    bit   ev;
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (chk_on && (cyc != rst_cyc)) begin
        if (m_pend_cyc <= cyc) m_busy = m_busy_pend;
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (out_valid) dut_pulses++;
        chk("out_valid", longint'(out_valid), longint'(ev));
        if (ev) begin
          e = q.pop_front();
          hold_l = e.l;
          hold_r = e.r;
          hold_c = e.c;
        end
        chk("out_L", longint'(out_L), longint'(hold_l));
        chk("out_R", longint'(out_R), longint'(hold_r));
        chk("clip", longint'(clip), longint'(hold_c));
        chk("ramp_busy", longint'(ramp_busy), longint'(m_busy));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      compare_loop();
    join_none

    do_reset(1'b0);
    chk_on = 1'b1;
    chk("rst_out_L", longint'(out_L), 0);
    chk("rst_out_R", longint'(out_R), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_ramp_busy", longint'(ramp_busy), 0);
    chk("rst_clip", longint'(clip), 0);
`ifdef OUTPUT_GAIN_RAMP_CLIP_COUNT_EN
    chk("rst_clip_count", longint'(clip_count), 0);
`endif

    // Ramp up from mute to unity, one sample every 4 cycles
    set_tgt(1'b1, 128);
    for (int k = 1; k <= 130; k++) begin
      send(1000, -1000);
      idle(3);
      if (k == 1)   chk("up_s1_L", longint'(out_L), 0);
      if (k == 1)   chk("up_s1_busy", longint'(ramp_busy), 1);
      if (k == 2)   chk("up_s2_L", longint'(out_L), 7);
      if (k == 2)   chk("up_s2_R", longint'(out_R), -8);
      if (k == 127) chk("up_s127_busy", longint'(ramp_busy), 1);
      if (k == 128) chk("up_s128_busy", longint'(ramp_busy), 0);
      if (k == 128) chk("up_s128_L", longint'(out_L), 992);
      if (k == 130) chk("up_s130_L", longint'(out_L), 1000);
    end

    // Unity hold
    send(-12345, 32'h7FFFFFFF);
    idle(3);
    chk("unity_L", longint'(out_L), -12345);
    chk("unity_R", longint'(out_R), 64'sh7FFFFFFF);
    chk("unity_clip", longint'(clip), 0);

    // Ramp to maximum gain, then saturate both rails
    set_tgt(1'b1, 255);
    repeat (127) send(100, -100);
    idle(3);
    chk("g255_busy", longint'(ramp_busy), 0);
`ifdef OUTPUT_GAIN_RAMP_CLIP_COUNT_EN
    cc0 = int'(clip_count);
`endif
    send(32'h7FFFFFFF, int'(32'h80000000));
    idle(3);
    chk("sat_L", longint'(out_L), 64'sh7FFFFFFF);
    chk("sat_R", longint'(out_R), -64'sh80000000);
    chk("sat_clip", longint'(clip), 1);
`ifdef OUTPUT_GAIN_RAMP_CLIP_COUNT_EN
    chk("sat_clip_count_delta", longint'(int'(clip_count) - cc0), 1);
`endif
    send(-3, 3);
    idle(3);
    chk("g255_neg_L", longint'(out_L), -6);
    chk("g255_pos_R", longint'(out_R), 5);
    chk("g255_clip", longint'(clip), 0);

    // Ramp down to 64, then mute by dropping enable
    set_tgt(1'b1, 64);
    repeat (191) send(100, 100);
    idle(3);
    chk("g64_busy", longint'(ramp_busy), 0);
    set_tgt(1'b0, 64);
    repeat (63) send(200, 200);
    idle(3);
    chk("mute63_busy", longint'(ramp_busy), 1);
    send(200, 200);
    idle(3);
    chk("mute64_busy", longint'(ramp_busy), 0);
    send(5000, -5000);
    idle(3);
    chk("muted_L", longint'(out_L), 0);
    chk("muted_R", longint'(out_R), 0);

    // Retarget mid-ramp, then back-to-back samples
    set_tgt(1'b1, 128);
    repeat (3) send(256, 256);
    set_tgt(1'b1, 2);
    send(256, 256);
    idle(3);
    chk("retarget_L", longint'(out_L), 6);
    chk("retarget_busy", longint'(ramp_busy), 0);
    set_tgt(1'b1, 128);
    p0 = dut_pulses;
    repeat (5) send(12800, -12800);
    idle(4);
    chk("b2b_pulses", longint'(dut_pulses - p0), 5);
    chk("b2b_last_L", longint'(out_L), 600);
    chk("b2b_last_R", longint'(out_R), -600);

    // Reset the cycle after a sample: that sample must never emerge
    p0 = dut_pulses;
    send(9999, 9999);
    do_reset(1'b0);
    idle(3);
    chk("rstmid_pulses", longint'(dut_pulses - p0), 0);
    chk("rstmid_valid", longint'(out_valid), 0);
    chk("rstmid_L", longint'(out_L), 0);
    chk("rstmid_R", longint'(out_R), 0);
    chk("rstmid_busy", longint'(ramp_busy), 0);

    // Samples offered during reset are ignored; first sample after uses gain 0
    do_reset(1'b1);
    chk("rstsv_valid", longint'(out_valid), 0);
    send(5000, 5000);
    idle(3);
    chk("post_rst_s1_L", longint'(out_L), 0);
    send(5000, 5000);
    idle(3);
    chk("post_rst_s2_L", longint'(out_L), 39);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
